// File: rtl/fm_ctrl_pkg.sv
// Shared definitions for the FM scan sequencer: FSM state encoding and
// the FM control-register address and command words.
package fm_ctrl_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_TUNE,
        S_SETTLE,
        S_SCAN_START,
        S_WAIT_IRQ,
        S_READ,
        S_SCAN_DONE,
        S_NEXT,
        S_FINAL_TUNE,
        S_RX_ON,
        S_FINISH
    } fm_state_e;

    localparam int unsigned FM_CTRL_ADDR   = 32'h004;
    localparam logic [31:0] CMD_RSSI_START = 32'h0000_0100;
    localparam logic [31:0] CMD_RSSI_DONE  = 32'h0000_0200;
    localparam logic [31:0] CMD_RX_ON      = 32'h0000_0010;
    localparam logic [31:0] CMD_RX_OFF     = 32'h0000_0020;

endpackage

// File: rtl/fm_wait_counter.sv
// Loadable down-counter; expired is high while the count sits at zero.
// One instance serves both the settle delay and the RSSI timeout.
module fm_wait_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             expired
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or posedge RST) begin
        if (RST)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (dec && cnt != '0)
            cnt <= cnt - 1'b1;
    end

    assign expired = (cnt == '0);

endmodule

// File: rtl/fm_scan_sequencer.sv
// FM band search: sweeps tuner channels, runs one RSSI scan per channel,
// keeps the strongest, then retunes and enables RX if it beats threshold.
module fm_scan_sequencer
    import fm_ctrl_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 6,
    parameter int          FREQ_WIDTH     = 11,
    parameter int          SETTLE_CYCLES  = 1024,
    parameter int          TIMEOUT_CYCLES = 65535,
    parameter logic [5:0]  RSSI_ADDR      = 6'h008
) (
    input  logic                  clk,
    input  logic                  RST,
    input  logic                  start,
    input  logic                  abort,
    input  logic [FREQ_WIDTH-1:0] freq_lo,
    input  logic [FREQ_WIDTH-1:0] freq_hi,
    input  logic [FREQ_WIDTH-1:0] step,
    input  logic [31:0]           threshold,
    output logic [FREQ_WIDTH-1:0] tune_freq,
    output logic                  tune_valid,
    input  logic                  tune_ack,
    output logic [ADDR_WIDTH-1:0] wraddr,
    output logic [31:0]           wdata,
    output logic [3:0]            wea,
    output logic [ADDR_WIDTH-1:0] rdaddr,
    input  logic [31:0]           rdata,
    input  logic                  RSSI_interrupt,
    output logic                  busy,
    output logic                  done,
    output logic                  found,
    output logic [FREQ_WIDTH-1:0] best_freq,
    output logic [31:0]           best_rssi,
    output logic                  timeout_err
);

    localparam int MAXC  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int CNT_W = (MAXC < 2) ? 1 : $clog2(MAXC + 1);

    fm_state_e             state, state_nxt;
    logic [FREQ_WIDTH-1:0] cur, hi_q, step_q;
    logic [31:0]           thr_q;
    logic                  win, abort_pend, found_q;
    logic                  cnt_load, cnt_dec, cnt_exp;
    logic [CNT_W-1:0]      cnt_val;
    logic [FREQ_WIDTH:0]   nxt;
    logic                  sweep_end, kill, off_mode, go;

    fm_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk      (clk),
        .RST      (RST),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .expired  (cnt_exp)
    );

    assign busy      = (state != S_IDLE) && (state != S_FINISH);
    assign done      = (state == S_FINISH);
    assign kill      = abort && busy;
    assign go        = (state == S_IDLE) && start && !abort;
    assign off_mode  = abort_pend || (best_rssi < thr_q);
    assign nxt       = {1'b0, cur} + {1'b0, step_q};
    // the extra bit catches wrap-around at the top of the code range
    assign sweep_end = nxt > {1'b0, hi_q};
    assign found     = done ? (win && !abort_pend) : found_q;

    always_comb begin
        state_nxt  = state;
        tune_valid = 1'b0;
        tune_freq  = '0;
        wraddr     = '0;
        wdata      = '0;
        wea        = 4'h0;
        rdaddr     = '0;
        cnt_load   = 1'b0;
        cnt_val    = '0;
        cnt_dec    = 1'b0;
        case (state)
            S_IDLE:
                if (go) state_nxt = (freq_lo > freq_hi) ? S_FINISH : S_TUNE;
            S_TUNE: begin
                tune_valid = 1'b1;
                tune_freq  = cur;
                if (kill) state_nxt = S_FINAL_TUNE;
                else if (tune_ack) begin
                    cnt_load  = 1'b1;
                    cnt_val   = CNT_W'(SETTLE_CYCLES - 1);
                    state_nxt = S_SETTLE;
                end
            end
            S_SETTLE:
                if (kill)         state_nxt = S_FINAL_TUNE;
                else if (cnt_exp) state_nxt = S_SCAN_START;
                else              cnt_dec   = 1'b1;
            S_SCAN_START: begin
                wraddr    = ADDR_WIDTH'(FM_CTRL_ADDR);
                wdata     = CMD_RSSI_START;
                wea       = 4'hF;
                cnt_load  = 1'b1;
                cnt_val   = CNT_W'(TIMEOUT_CYCLES - 1);
                state_nxt = kill ? S_FINAL_TUNE : S_WAIT_IRQ;
            end
            S_WAIT_IRQ:
                if (kill) state_nxt = S_FINAL_TUNE;
                else if (RSSI_interrupt) begin
                    rdaddr    = ADDR_WIDTH'(RSSI_ADDR);
                    state_nxt = S_READ;
                end
                else if (cnt_exp) state_nxt = S_SCAN_DONE;
                else              cnt_dec   = 1'b1;
            S_READ: begin
                rdaddr    = ADDR_WIDTH'(RSSI_ADDR);
                state_nxt = kill ? S_FINAL_TUNE : S_SCAN_DONE;
            end
            S_SCAN_DONE: begin
                wraddr    = ADDR_WIDTH'(FM_CTRL_ADDR);
                wdata     = CMD_RSSI_DONE;
                wea       = 4'hF;
                state_nxt = kill ? S_FINAL_TUNE : S_NEXT;
            end
            S_NEXT:
                state_nxt = (kill || sweep_end) ? S_FINAL_TUNE : S_TUNE;
            S_FINAL_TUNE:
                // an abort seen mid-handshake turns this state into the RX OFF write
                if (off_mode) begin
                    wraddr    = ADDR_WIDTH'(FM_CTRL_ADDR);
                    wdata     = CMD_RX_OFF;
                    wea       = 4'hF;
                    state_nxt = S_FINISH;
                end else begin
                    tune_valid = 1'b1;
                    tune_freq  = best_freq;
                    if (!kill && tune_ack) state_nxt = S_RX_ON;
                end
            S_RX_ON: begin
                wraddr    = ADDR_WIDTH'(FM_CTRL_ADDR);
                wdata     = CMD_RX_ON;
                wea       = 4'hF;
                state_nxt = kill ? S_FINAL_TUNE : S_FINISH;
            end
            S_FINISH:
                state_nxt = S_IDLE;
            default:
                state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state       <= S_IDLE;
            cur         <= '0;
            hi_q        <= '0;
            step_q      <= '0;
            thr_q       <= '0;
            best_freq   <= '0;
            best_rssi   <= '0;
            timeout_err <= 1'b0;
            win         <= 1'b0;
            abort_pend  <= 1'b0;
            found_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (go) begin
                timeout_err <= 1'b0;
                win         <= 1'b0;
                abort_pend  <= 1'b0;
                if (freq_lo <= freq_hi) begin
                    cur       <= freq_lo;
                    hi_q      <= freq_hi;
                    step_q    <= (step == '0) ? FREQ_WIDTH'(1) : step;
                    thr_q     <= threshold;
                    best_rssi <= '0;
                    best_freq <= freq_lo;
                end
            end
            if (kill) abort_pend <= 1'b1;
            if (state == S_WAIT_IRQ && !kill && !RSSI_interrupt && cnt_exp)
                timeout_err <= 1'b1;
            if (state == S_READ && rdata > best_rssi) begin
                best_rssi <= rdata;
                best_freq <= cur;
            end
            if (state == S_NEXT && !kill && !sweep_end)
                cur <= nxt[FREQ_WIDTH-1:0];
            if (state == S_FINAL_TUNE && !off_mode && !kill && tune_ack)
                win <= 1'b1;
            if (state == S_FINISH)
                found_q <= win && !abort_pend;
        end
    end

endmodule

// File: tb/tb_fm_scan_sequencer.sv
// Directed bench for fm_scan_sequencer with a tuner/FM-block model and
// write/tune logs compared against hand-computed sequences.
module tb_fm_scan_sequencer;

    logic        clk = 1'b0;
    logic        RST = 1'b1;
    logic        start = 1'b0, abort = 1'b0;
    logic [10:0] freq_lo = '0, freq_hi = '0, step = '0;
    logic [31:0] threshold = '0;
    logic [10:0] tune_freq;
    logic        tune_valid;
    logic        tune_ack = 1'b0;
    logic [5:0]  wraddr, rdaddr;
    logic [31:0] wdata;
    logic [3:0]  wea;
    logic [31:0] rdata = '0;
    logic        RSSI_interrupt = 1'b0;
    logic        busy, done, found, timeout_err;
    logic [10:0] best_freq;
    logic [31:0] best_rssi;

    int n_tests = 0, n_fail = 0;

    fm_scan_sequencer #(.SETTLE_CYCLES(8), .TIMEOUT_CYCLES(50)) dut (
        .clk(clk), .RST(RST), .start(start), .abort(abort),
        .freq_lo(freq_lo), .freq_hi(freq_hi), .step(step), .threshold(threshold),
        .tune_freq(tune_freq), .tune_valid(tune_valid), .tune_ack(tune_ack),
        .wraddr(wraddr), .wdata(wdata), .wea(wea), .rdaddr(rdaddr), .rdata(rdata),
        .RSSI_interrupt(RSSI_interrupt), .busy(busy), .done(done), .found(found),
        .best_freq(best_freq), .best_rssi(best_rssi), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // tuner: ack one cycle after a request appears
    always @(posedge clk) tune_ack <= tune_valid & ~tune_ack;

    // FM block: irq three cycles after an RSSI start, synchronous read port
    logic [31:0] rssi_tab [4];
    int          withhold = -1;
    logic        model_clr = 1'b0;
    int          scan_idx = 0, lat_idx = 0, irq_cnt = 0;
    always @(posedge clk) begin
        RSSI_interrupt <= 1'b0;
        rdata <= (rdaddr == 6'h08) ? rssi_tab[lat_idx & 3] : 32'h0;
        if (model_clr) begin
            scan_idx <= 0;
            irq_cnt  <= 0;
        end else if (wea == 4'hF && wraddr == 6'h04 && wdata == 32'h100) begin
            lat_idx  <= scan_idx;
            scan_idx <= scan_idx + 1;
            if (scan_idx != withhold) irq_cnt <= 3;
        end else if (irq_cnt != 0) begin
            irq_cnt <= irq_cnt - 1;
            if (irq_cnt == 1) RSSI_interrupt <= 1'b1;
        end
    end

    logic [31:0] wlog[$];
    logic [31:0] tlog[$];
    always @(negedge clk) begin
        if (wea != 4'h0) wlog.push_back(wdata);
        if (tune_valid && tune_ack) tlog.push_back({21'b0, tune_freq});
    end

    int wbase = 0, tbase = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic chk_log(input string tag, input logic [31:0] lg[$], input int base,
                           input logic [31:0] eq[$]);
        chk({tag, "_n"}, 32'(lg.size() - base), 32'(eq.size()));
        for (int i = 0; i < eq.size(); i++)
            if (base + i < lg.size()) chk($sformatf("%s_%0d", tag, i), lg[base + i], eq[i]);
    endtask

    task automatic wait_done(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (done) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk({tag, "_done_seen"}, 32'(ok), 32'd1);
    endtask

    task automatic launch(input logic [10:0] lo, input logic [10:0] hi, input logic [10:0] st,
                          input logic [31:0] thr, input int wh);
        freq_lo = lo; freq_hi = hi; step = st; threshold = thr; withhold = wh;
        model_clr = 1'b1;
        @(negedge clk);
        model_clr = 1'b0;
        wbase = wlog.size();
        tbase = tlog.size();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    logic [31:0] eq[$];
    int          bad;

    initial begin
        rssi_tab[0] = 5; rssi_tab[1] = 9; rssi_tab[2] = 7; rssi_tab[3] = 0;
        repeat (3) @(negedge clk);
        chk("rst_outs", {busy, done, found, timeout_err, tune_valid, wea}, 32'h0);
        chk("rst_addr", {wraddr, rdaddr, tune_freq}, 32'h0);
        chk("rst_best", {21'b0, best_freq} | best_rssi, 32'h0);
        RST = 1'b0;
        @(negedge clk);

        // A: peak at 102, above threshold
        launch(100, 104, 2, 8, -1);
        chk("A_busy", 32'(busy), 32'd1);
        wait_done("A");
        chk("A_found", 32'(found), 32'd1);
        chk("A_bfreq", 32'(best_freq), 32'd102);
        chk("A_brssi", best_rssi, 32'd9);
        chk("A_busy_done", 32'(busy), 32'd0);
        chk("A_tmo", 32'(timeout_err), 32'd0);
        eq = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h10};
        chk_log("A_wr", wlog, wbase, eq);
        eq = '{32'd100, 32'd102, 32'd104, 32'd102};
        chk_log("A_tune", tlog, tbase, eq);
        @(negedge clk);
        chk("A_done_pulse", 32'(done), 32'd0);
        chk("A_found_hold", 32'(found), 32'd1);

        // B: same sweep, threshold out of reach
        launch(100, 104, 2, 10, -1);
        wait_done("B");
        chk("B_found", 32'(found), 32'd0);
        chk("B_bfreq", 32'(best_freq), 32'd102);
        eq = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h20};
        chk_log("B_wr", wlog, wbase, eq);
        eq = '{32'd100, 32'd102, 32'd104};
        chk_log("B_tune", tlog, tbase, eq);

        // T: second channel never interrupts
        launch(100, 104, 2, 6, 1);
        wait_done("T");
        chk("T_tmo", 32'(timeout_err), 32'd1);
        chk("T_found", 32'(found), 32'd1);
        chk("T_bfreq", 32'(best_freq), 32'd104);
        chk("T_brssi", best_rssi, 32'd7);
        eq = '{32'h100, 32'h200, 32'h100, 32'h200, 32'h100, 32'h200, 32'h10};
        chk_log("T_wr", wlog, wbase, eq);

        // E: empty range finishes immediately
        launch(50, 40, 1, 0, -1);
        chk("E_done_lat", 32'(done), 32'd1);
        chk("E_found", 32'(found), 32'd0);
        chk("E_tmo_clr", 32'(timeout_err), 32'd0);
        @(negedge clk);
        chk("E_wr_n", 32'(wlog.size() - wbase), 32'd0);

        // S: step 0 on a single-channel range
        rssi_tab[0] = 3;
        launch(7, 7, 0, 1, -1);
        wait_done("S");
        chk("S_found", 32'(found), 32'd1);
        chk("S_bfreq", 32'(best_freq), 32'd7);
        chk("S_brssi", best_rssi, 32'd3);
        eq = '{32'h100, 32'h200, 32'h10};
        chk_log("S_wr", wlog, wbase, eq);
        eq = '{32'd7, 32'd7};
        chk_log("S_tune", tlog, tbase, eq);
        rssi_tab[0] = 5;

        // AB: abort while settling on the second channel
        launch(100, 104, 2, 1, -1);
        for (int i = 0; i < 500 && (tlog.size() - tbase) < 2; i++) @(negedge clk);
        chk("AB_reach", 32'(tlog.size() - tbase), 32'd2);
        repeat (2) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done("AB");
        chk("AB_found", 32'(found), 32'd0);
        chk("AB_busy", 32'(busy), 32'd0);
        eq = '{32'h100, 32'h200, 32'h20};
        chk_log("AB_wr", wlog, wbase, eq);

        // R: reset while waiting for an interrupt that never comes
        launch(100, 104, 2, 1, 0);
        for (int i = 0; i < 500 && (wlog.size() - wbase) < 1; i++) @(negedge clk);
        chk("R_started", 32'(wlog.size() - wbase), 32'd1);
        repeat (3) @(negedge clk);
        RST = 1'b1;
        @(negedge clk);
        chk("R_outs", {busy, done, found, timeout_err, tune_valid, wea}, 32'h0);
        chk("R_addr", {wraddr, rdaddr, tune_freq}, 32'h0);
        chk("R_best", {21'b0, best_freq} | best_rssi, 32'h0);
        @(negedge clk);
        RST = 1'b0;
        wbase = wlog.size();
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy || done || wea != 4'h0 || found) bad++;
        end
        chk("R_quiet", 32'(bad), 32'd0);
        chk("R_wr_n", 32'(wlog.size() - wbase), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fm_scan_sequencer.md
Name: fm_scan_sequencer

Overview:
- Controller that automates an FM band search on the FM hardware block.
- Steps a tuner frequency from freq_lo to freq_hi and commands one RSSI scan per channel over the FM control write bus (address 0x004).
- Collects each RSSI result over the read bus and tracks the strongest channel.
- Retunes to the best channel above threshold and switches the receiver on; otherwise leaves the receiver off.

Parameters:
- ADDR_WIDTH, 6: width of wraddr/rdaddr, matching the FM bus.
- FREQ_WIDTH, 11: channel code width (tuner units, e.g. 100 kHz steps).
- SETTLE_CYCLES, 1024: clk cycles to wait after tune_ack before starting a scan.
- TIMEOUT_CYCLES, 65535: maximum clk cycles to wait for RSSI_interrupt.
- RSSI_ADDR, 6'h008: rdaddr used to fetch the RSSI result.

Ports:
- clk  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- start  in  1  one-cycle pulse; begins a search when idle
- abort  in  1  one-cycle pulse; cancels the search
- freq_lo  in  FREQ_WIDTH  first channel
- freq_hi  in  FREQ_WIDTH  last channel
- step  in  FREQ_WIDTH  channel increment; 0 is treated as 1
- threshold  in  32  minimum RSSI for a valid station
- tune_freq  out  FREQ_WIDTH  frequency requested from the tuner
- tune_valid  out  1  tuner request, held until tune_ack
- tune_ack  in  1  tuner locked
- wraddr  out  ADDR_WIDTH  FM control write address
- wdata  out  32  FM control write data
- wea  out  4  byte enables; 4'hF while writing, otherwise 0
- rdaddr  out  ADDR_WIDTH  FM read address
- rdata  in  32  FM read data
- RSSI_interrupt  in  1  scan-complete pulse from the FM block
- busy  out  1  search in progress
- done  out  1  one-cycle pulse at end of search
- found  out  1  best_rssi >= threshold (valid with done, held afterwards)
- best_freq  out  FREQ_WIDTH  strongest channel
- best_rssi  out  32  its RSSI
- timeout_err  out  1  sticky; cleared by start

Behaviour:
- Reset values:
  - all outputs 0; best_freq 0; best_rssi 0.
  - wraddr and rdaddr are 0.
  - FSM is in IDLE.
- RST asserted mid-search: no write is completed or issued afterwards; the block returns to IDLE silently.
- FSM states: IDLE, TUNE, SETTLE, SCAN_START, WAIT_IRQ, READ, SCAN_DONE, NEXT, FINAL_TUNE, RX_ON, FINISH.
- IDLE --start-->
  - If freq_lo > freq_hi, go directly to FINISH with found=0 and issue no bus writes.
  - Otherwise: cur=freq_lo, best_rssi=0, best_freq=freq_lo, clear timeout_err, busy=1, go to TUNE.
  - start is ignored while busy.
- TUNE: tune_freq=cur, tune_valid=1 until tune_ack is sampled high. Then load the settle counter and go to SETTLE.
- SETTLE: count SETTLE_CYCLES, then go to SCAN_START.
- SCAN_START: one cycle with wraddr=0x004, wdata=32'h0000_0100, wea=4'hF. Then WAIT_IRQ with the timeout counter cleared.
- WAIT_IRQ:
  - On RSSI_interrupt, drive rdaddr=RSSI_ADDR and go to READ.
  - On timeout, set timeout_err, treat the RSSI as 0, and go to SCAN_DONE.
- READ: rdata is sampled one cycle after rdaddr is driven. If rdata > best_rssi (strict compare; on a tie the first channel wins), update best_rssi and best_freq.
- SCAN_DONE: one write of wdata=32'h0000_0200 to 0x004.
- NEXT: compute nxt=cur+step at FREQ_WIDTH+1 bits.
  - If nxt > freq_hi or the add carries out, go to FINAL_TUNE.
  - Otherwise cur=nxt and go to TUNE.
- FINAL_TUNE:
  - If best_rssi >= threshold: tune best_freq (same handshake as TUNE), then RX_ON.
  - Otherwise write 32'h0000_0020 (RX OFF), then FINISH.
- RX_ON: one write of 32'h0000_0010, then FINISH.
- FINISH: done=1 for one cycle, busy=0, found latched, back to IDLE.
- abort while busy:
  - Any in-flight single-cycle write completes first.
  - Then one RX OFF write (32'h0000_0020), then FINISH with found=0.
  - If abort and start arrive in the same cycle while IDLE, abort wins (no search starts).
- Bus writes are exactly one cycle. There is never more than one write per state entry.

Decomposition:
- Shared package fm_ctrl_pkg holds:
  - the FSM state enum;
  - the constants FM_CTRL_ADDR=0x004, CMD_RSSI_START=32'h100, CMD_RSSI_DONE=32'h200, CMD_RX_ON=32'h10, CMD_RX_OFF=32'h20.
- One natural sub-module: fm_wait_counter, a loadable down-counter with an expiry flag, shared by settle and timeout.

Test Plan:
- freq_lo=100, freq_hi=104, step=2, RSSI model returns 5/9/7, threshold=8 → three START/DONE write pairs at tune 100/102/104, then final tune 102, RX_ON write, done with found=1, best_freq=102, best_rssi=9.
- Same sweep with threshold=10 → RX_OFF write, found=0, best_freq=102.
- Interrupt withheld on the second channel → timeout_err=1 after TIMEOUT_CYCLES, DONE write still issued, sweep continues and done pulses.
- freq_lo=50, freq_hi=40 → done on the cycle after start, zero bus writes, found=0.
- step=0, lo=hi=7 → a single scan, treated as step 1 with no infinite loop.
- abort during SETTLE on the second channel → one RX_OFF write, done, found=0, busy=0.
- RST pulse during WAIT_IRQ → all outputs are 0 during and after the pulse, and no further writes occur.
